// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the two-master split-transaction bus arbiter.
package bus_arb_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        M1_GNT     = 3'd1,
        M2_GNT     = 3'd2,
        TURNAROUND = 3'd3,
        TIMEOUT    = 3'd4
    } arb_state_t;

    localparam int M1_IDX      = 0;
    localparam int M2_IDX      = 1;
    localparam int NUM_MASTERS = 2;

    localparam int DEFAULT_TIMEOUT_CYCLES = 255;
    localparam int DEFAULT_CNT_W          = 8;

    // Round-robin tie winner: the master that did not hold the bus last.
    function automatic logic rr_winner(input logic last_idx);
        return ~last_idx;
    endfunction

endpackage

// File: rtl/grant_hold_timer.sv
// Grant-hold counter: synchronous clear, count enable, saturates at
// TIMEOUT_CYCLES-1 and flags that terminal value.
module grant_hold_timer #(
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (enable && (count_reg != TC_VAL)) begin
            count_next = count_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign terminal = (count_reg == TC_VAL);

endmodule

// File: rtl/bus_arbiter_split.sv
// Two-master round-robin bus arbiter with split-transaction parking and a
// grant-hold watchdog. Define ARB_FIXED_PRIORITY_EN to make M1 win every tie.
module bus_arbiter_split
    import bus_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEFAULT_CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m1_req,
    input  logic       m2_req,
    input  logic       m1_release,
    input  logic       m2_release,
    input  logic       bus_split,
    input  logic [1:0] split_release,
    output logic       m1_grant,
    output logic       m2_grant,
    output logic       bus_busy,
    output logic       timeout_flag,
    output logic [1:0] split_pending,
    output logic [2:0] arbiter_state
);

    arb_state_t state_reg;
    arb_state_t state_next;
    logic       last_reg;       // index of the master granted most recently
    logic       last_next;
    logic [NUM_MASTERS-1:0] split_reg;
    logic [NUM_MASTERS-1:0] split_next;
    logic [NUM_MASTERS-1:0] split_set;
    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] elig;
    logic       grant_entry;
    logic       in_grant;
    logic       terminal;

    assign req  = {m2_req, m1_req};
    assign elig = req & ~split_reg;

    always_comb begin
        state_next  = state_reg;
        last_next   = last_reg;
        split_set   = '0;
        grant_entry = 1'b0;
        case (state_reg)
            IDLE: begin
                if (elig[M1_IDX] && elig[M2_IDX]) begin
`ifdef ARB_FIXED_PRIORITY_EN
                    state_next = M1_GNT;
`else
                    state_next = (rr_winner(last_reg) == 1'(M1_IDX)) ? M1_GNT : M2_GNT;
`endif
                end else if (elig[M1_IDX]) begin
                    state_next = M1_GNT;
                end else if (elig[M2_IDX]) begin
                    state_next = M2_GNT;
                end
                if (state_next == M1_GNT) begin
                    grant_entry = 1'b1;
                    last_next   = 1'(M1_IDX);
                end else if (state_next == M2_GNT) begin
                    grant_entry = 1'b1;
                    last_next   = 1'(M2_IDX);
                end
            end
            M1_GNT: begin
                if (bus_split) begin
                    split_set[M1_IDX] = 1'b1;
                    state_next        = TURNAROUND;
                end else if (m1_release) begin
                    state_next = TURNAROUND;
                end else if (terminal) begin
                    state_next = TIMEOUT;
                end
            end
            M2_GNT: begin
                if (bus_split) begin
                    split_set[M2_IDX] = 1'b1;
                    state_next        = TURNAROUND;
                end else if (m2_release) begin
                    state_next = TURNAROUND;
                end else if (terminal) begin
                    state_next = TIMEOUT;
                end
            end
            TURNAROUND: state_next = IDLE;
            TIMEOUT:    state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // A park request in the same cycle as its un-park wins.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_split
            assign split_next[gi] = split_set[gi] | (split_reg[gi] & ~split_release[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            last_reg  <= 1'(M2_IDX);
            split_reg <= '0;
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
            split_reg <= split_next;
        end
    end

    assign in_grant = (state_reg == M1_GNT) || (state_reg == M2_GNT);

    grant_hold_timer #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_hold_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (grant_entry),
        .enable   (in_grant),
        .terminal (terminal)
    );

    assign m1_grant      = (state_reg == M1_GNT);
    assign m2_grant      = (state_reg == M2_GNT);
    assign bus_busy      = in_grant;
    assign timeout_flag  = (state_reg == TIMEOUT);
    assign split_pending = split_reg;
    assign arbiter_state = state_reg;

endmodule

// File: tb/tb_bus_arbiter_split.sv
// Self-checking bench for bus_arbiter_split: grant ownership predicted into a
// scoreboard queue at stimulus time and compared when a grant appears.
module tb_bus_arbiter_split;

    localparam int T_CYC = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       m1_req = 1'b0;
    logic       m2_req = 1'b0;
    logic       m1_release = 1'b0;
    logic       m2_release = 1'b0;
    logic       bus_split = 1'b0;
    logic [1:0] split_release = 2'b00;
    logic       m1_grant;
    logic       m2_grant;
    logic       bus_busy;
    logic       timeout_flag;
    logic [1:0] split_pending;
    logic [2:0] arbiter_state;

    int checks = 0;
    int failures = 0;
    int sb[$];
    int model_last = 1;

    bus_arbiter_split #(
        .TIMEOUT_CYCLES (T_CYC),
        .CNT_W          (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .m1_req        (m1_req),
        .m2_req        (m2_req),
        .m1_release    (m1_release),
        .m2_release    (m2_release),
        .bus_split     (bus_split),
        .split_release (split_release),
        .m1_grant      (m1_grant),
        .m2_grant      (m2_grant),
        .bus_busy      (bus_busy),
        .timeout_flag  (timeout_flag),
        .split_pending (split_pending),
        .arbiter_state (arbiter_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int predict(input logic e1, input logic e2);
        if (e1 && e2) begin
`ifdef ARB_FIXED_PRIORITY_EN
            return 0;
`else
            return (model_last == 1) ? 0 : 1;
`endif
        end
        if (e1) return 0;
        return 1;
    endfunction

    task automatic push_expect(input logic e1, input logic e2);
        int w;
        w = predict(e1, e2);
        sb.push_back(w);
        model_last = w;
    endtask

    task automatic wait_grant(output int who);
        who = -1;
        for (int i = 0; i < 8; i++) begin
            if (bus_busy) begin
                who = m1_grant ? 0 : 1;
                break;
            end
            step();
        end
        if (who < 0) begin
            checks++;
            failures++;
            $display("FAIL grant_wait: got no grant within 8 cycles, expected a grant");
        end
    endtask

    task automatic release_master(input int who);
        if (who == 0) m1_release = 1'b1;
        if (who == 1) m2_release = 1'b1;
        step();
        m1_release = 1'b0;
        m2_release = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        checks++;
        if ({m1_grant, m2_grant, bus_busy, timeout_flag} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 0000", {m1_grant, m2_grant, bus_busy, timeout_flag});
        end
        checks++;
        if (split_pending !== 2'b00) begin
            failures++;
            $display("FAIL reset_split: got %b expected 00", split_pending);
        end
        checks++;
        if (arbiter_state !== 3'd0) begin
            failures++;
            $display("FAIL reset_state: got %0d expected 0", arbiter_state);
        end
        reset = 1'b1;
        step();
        $display("reset: state=%0d grants=%b%b", arbiter_state, m2_grant, m1_grant);
    endtask

    task automatic test_basic();
        int who;
        int exp;
        step();
        m1_req = 1'b1;
        push_expect(1'b1, 1'b0);
        step();
        checks++;
        if (m1_grant !== 1'b1 || arbiter_state !== 3'd1) begin
            failures++;
            $display("FAIL basic_latency: got grant=%b state=%0d expected grant=1 state=1", m1_grant, arbiter_state);
        end
        wait_grant(who);
        exp = sb.pop_front();
        checks++;
        if (who !== exp) begin
            failures++;
            $display("FAIL basic_owner: got %0d expected %0d", who, exp);
        end
        m1_req = 1'b0;
        step();
        step();
        release_master(0);
        checks++;
        if (m1_grant !== 1'b0 || arbiter_state !== 3'd3) begin
            failures++;
            $display("FAIL basic_release: got grant=%b state=%0d expected grant=0 state=3", m1_grant, arbiter_state);
        end
        step();
        checks++;
        if (arbiter_state !== 3'd0) begin
            failures++;
            $display("FAIL basic_idle: got %0d expected 0", arbiter_state);
        end
        $display("basic: M1 granted and released, owner=%0d", who);
    endtask

    task automatic test_round_robin();
        int who;
        int exp;
        m1_req = 1'b1;
        m2_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push_expect(1'b1, 1'b1);
            wait_grant(who);
            exp = sb.pop_front();
            checks++;
            if (who !== exp) begin
                failures++;
                $display("FAIL rr_owner[%0d]: got %0d expected %0d", k, who, exp);
            end
            step();
            step();
            release_master(who);
            checks++;
            if (bus_busy !== 1'b0 || arbiter_state !== 3'd3) begin
                failures++;
                $display("FAIL rr_turnaround[%0d]: got busy=%b state=%0d expected busy=0 state=3", k, bus_busy, arbiter_state);
            end
            step();
            if (k == 3) begin
                m1_req = 1'b0;
                m2_req = 1'b0;
            end
            $display("round_robin[%0d]: owner=%0d expected=%0d", k, who, exp);
        end
        step();
    endtask

    task automatic test_split();
        int who;
        int exp;
        m2_req = 1'b1;
        push_expect(1'b0, 1'b1);
        wait_grant(who);
        exp = sb.pop_front();
        checks++;
        if (who !== exp) begin
            failures++;
            $display("FAIL split_owner_m2: got %0d expected %0d", who, exp);
        end
        bus_split = 1'b1;
        step();
        bus_split = 1'b0;
        checks++;
        if (split_pending !== 2'b10 || arbiter_state !== 3'd3) begin
            failures++;
            $display("FAIL split_park: got pending=%b state=%0d expected pending=10 state=3", split_pending, arbiter_state);
        end
        m1_req = 1'b1;
        push_expect(1'b1, 1'b0);
        wait_grant(who);
        exp = sb.pop_front();
        checks++;
        if (who !== exp) begin
            failures++;
            $display("FAIL split_masked: got %0d expected %0d", who, exp);
        end
        m1_req = 1'b0;
        release_master(0);
        step();
        step();
        step();
        checks++;
        if (bus_busy !== 1'b0) begin
            failures++;
            $display("FAIL split_hold_off: got busy=%b expected 0", bus_busy);
        end
        split_release = 2'b10;
        step();
        split_release = 2'b00;
        checks++;
        if (split_pending !== 2'b00) begin
            failures++;
            $display("FAIL split_unpark: got %b expected 00", split_pending);
        end
        push_expect(1'b0, 1'b1);
        wait_grant(who);
        exp = sb.pop_front();
        checks++;
        if (who !== exp) begin
            failures++;
            $display("FAIL split_resume: got %0d expected %0d", who, exp);
        end
        m2_req = 1'b0;
        release_master(1);
        step();
        $display("split: M2 parked, M1 served, M2 resumed owner=%0d", who);
    endtask

    task automatic test_timeout();
        int who;
        int exp;
        int hold;
        m1_req = 1'b1;
        push_expect(1'b1, 1'b0);
        wait_grant(who);
        exp = sb.pop_front();
        checks++;
        if (who !== exp) begin
            failures++;
            $display("FAIL timeout_owner: got %0d expected %0d", who, exp);
        end
        m1_req = 1'b0;
        hold = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (m1_grant) hold++;
            else break;
        end
        checks++;
        if (hold !== T_CYC) begin
            failures++;
            $display("FAIL timeout_hold: got %0d cycles expected %0d", hold, T_CYC);
        end
        checks++;
        if (arbiter_state !== 3'd4 || timeout_flag !== 1'b1) begin
            failures++;
            $display("FAIL timeout_pulse: got state=%0d flag=%b expected state=4 flag=1", arbiter_state, timeout_flag);
        end
        step();
        checks++;
        if (arbiter_state !== 3'd0 || timeout_flag !== 1'b0) begin
            failures++;
            $display("FAIL timeout_end: got state=%0d flag=%b expected state=0 flag=0", arbiter_state, timeout_flag);
        end
        $display("timeout: hold=%0d cycles", hold);
    endtask

    task automatic test_corner_cases();
        int who;
        int exp;
        m2_req = 1'b1;
        push_expect(1'b0, 1'b1);
        wait_grant(who);
        exp = sb.pop_front();
        checks++;
        if (who !== exp) begin
            failures++;
            $display("FAIL tc_owner: got %0d expected %0d", who, exp);
        end
        m2_req = 1'b0;
        step();
        step();
        step();
        checks++;
        if (m2_grant !== 1'b1) begin
            failures++;
            $display("FAIL tc_still_granted: got %b expected 1", m2_grant);
        end
        release_master(1);
        checks++;
        if (arbiter_state !== 3'd3 || timeout_flag !== 1'b0) begin
            failures++;
            $display("FAIL tc_release_wins: got state=%0d flag=%b expected state=3 flag=0", arbiter_state, timeout_flag);
        end
        step();
        checks++;
        if (arbiter_state !== 3'd0 || timeout_flag !== 1'b0) begin
            failures++;
            $display("FAIL tc_no_timeout: got state=%0d flag=%b expected state=0 flag=0", arbiter_state, timeout_flag);
        end
        $display("corner: release at terminal count, state=%0d", arbiter_state);

        m1_req = 1'b1;
        push_expect(1'b1, 1'b0);
        wait_grant(who);
        exp = sb.pop_front();
        checks++;
        if (who !== exp) begin
            failures++;
            $display("FAIL split_rel_owner: got %0d expected %0d", who, exp);
        end
        m1_req = 1'b0;
        bus_split = 1'b1;
        m1_release = 1'b1;
        step();
        bus_split = 1'b0;
        m1_release = 1'b0;
        checks++;
        if (split_pending !== 2'b01 || arbiter_state !== 3'd3) begin
            failures++;
            $display("FAIL split_over_release: got pending=%b state=%0d expected pending=01 state=3", split_pending, arbiter_state);
        end
        step();
        m2_req = 1'b1;
        push_expect(1'b0, 1'b1);
        wait_grant(who);
        exp = sb.pop_front();
        checks++;
        if (who !== exp) begin
            failures++;
            $display("FAIL set_wins_owner: got %0d expected %0d", who, exp);
        end
        m2_req = 1'b0;
        bus_split = 1'b1;
        split_release = 2'b10;
        step();
        bus_split = 1'b0;
        split_release = 2'b00;
        checks++;
        if (split_pending !== 2'b11) begin
            failures++;
            $display("FAIL set_wins: got %b expected 11", split_pending);
        end
        step();
        split_release = 2'b11;
        step();
        split_release = 2'b00;
        checks++;
        if (split_pending !== 2'b00) begin
            failures++;
            $display("FAIL unpark_both: got %b expected 00", split_pending);
        end
        $display("corner: split beats release and beats un-park");
    endtask

    task automatic test_async_reset();
        int who;
        int exp;
        m2_req = 1'b1;
        push_expect(1'b0, 1'b1);
        wait_grant(who);
        exp = sb.pop_front();
        checks++;
        if (who !== exp) begin
            failures++;
            $display("FAIL areset_m2_owner: got %0d expected %0d", who, exp);
        end
        m2_req = 1'b0;
        bus_split = 1'b1;
        step();
        bus_split = 1'b0;
        m1_req = 1'b1;
        push_expect(1'b1, 1'b0);
        wait_grant(who);
        exp = sb.pop_front();
        checks++;
        if (who !== exp) begin
            failures++;
            $display("FAIL areset_m1_owner: got %0d expected %0d", who, exp);
        end
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if ({m1_grant, m2_grant, bus_busy} !== 3'b000 || split_pending !== 2'b00 || arbiter_state !== 3'd0) begin
            failures++;
            $display("FAIL areset_immediate: got grants=%b%b busy=%b pending=%b state=%0d expected all 0",
                     m2_grant, m1_grant, bus_busy, split_pending, arbiter_state);
        end
        #2;
        reset = 1'b1;
        model_last = 1;
        m1_req = 1'b1;
        m2_req = 1'b1;
        push_expect(1'b1, 1'b1);
        wait_grant(who);
        exp = sb.pop_front();
        checks++;
        if (who !== exp) begin
            failures++;
            $display("FAIL areset_tie: got %0d expected %0d", who, exp);
        end
        m1_req = 1'b0;
        m2_req = 1'b0;
        release_master(who);
        step();
        $display("async_reset: grants dropped, first tie owner=%0d", who);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_split();
        test_timeout();
        test_corner_cases();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d leftover expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

endmodule
